// File: rtl/conv_mac_array.sv
// Multi-lane signed MAC for convolution windows: one shared pixel stream, LANES weight streams,
// saturating/ReLU result register with valid/ready handshake on both sides.
module conv_mac_array #(
    parameter int unsigned DATA_W = 9,
    parameter int unsigned LANES  = 4,
    parameter int unsigned OUT_W  = 21,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned ACC_W  = 2 * DATA_W + CNT_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      relu_en,
    input  logic [CNT_W-1:0]          win_len,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATA_W-1:0]  pixel,
    input  logic [LANES*DATA_W-1:0]   weight,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*OUT_W-1:0]    out_data,
    output logic [LANES-1:0]          out_sat
);

    if (ACC_W < 2 * DATA_W + CNT_W || OUT_W > ACC_W) begin : g_param_check
        $error("conv_mac_array: ACC_W must be >= 2*DATA_W+CNT_W and >= OUT_W");
    end

    typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [CNT_W-1:0]        len_q, len_d;
    logic [CNT_W-1:0]        eff_len;
    logic signed [ACC_W-1:0] acc_q [LANES];
    logic signed [ACC_W-1:0] acc_d [LANES];
    logic signed [ACC_W-1:0] sum_a [LANES];
    logic [LANES*OUT_W-1:0]  data_q, data_d, lane_res;
    logic [LANES-1:0]        sat_q, sat_d, lane_clip;
    logic                    valid_q, valid_d;
    logic                    last_beat, fire;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [DATA_W-1:0]   w;
        logic signed [2*DATA_W-1:0] prod;
        logic signed [OUT_W-1:0]    res;
        logic                       clip;

        assign w    = weight[k*DATA_W +: DATA_W];
        assign prod = $signed({{DATA_W{pixel[DATA_W-1]}}, pixel})
                    * $signed({{DATA_W{w[DATA_W-1]}}, w});
        assign sum_a[k] = acc_q[k] + $signed({{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod});

        // ReLU is applied after clipping so it never affects the saturation flag.
        always_comb begin
            clip = 1'b0;
            res  = sum_a[k][OUT_W-1:0];
            if (sum_a[k] > SAT_MAX) begin
                res  = SAT_MAX[OUT_W-1:0];
                clip = 1'b1;
            end else if (sum_a[k] < SAT_MIN) begin
                res  = SAT_MIN[OUT_W-1:0];
                clip = 1'b1;
            end
            if (relu_en && res[OUT_W-1]) begin
                res = '0;
            end
        end

        assign lane_res[k*OUT_W +: OUT_W] = res;
        assign lane_clip[k]               = clip;
    end

    // Window length comes straight from win_len until the first beat latches it.
    always_comb begin
        eff_len   = (count_q == '0) ? ((win_len == '0) ? CNT_W'(1) : win_len) : len_q;
        last_beat = (count_q + CNT_W'(1)) == eff_len;
        in_ready  = !(last_beat && valid_q && !out_ready);
        fire      = in_valid && in_ready && !clear;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        len_d   = len_q;
        valid_d = valid_q;
        data_d  = data_q;
        sat_d   = sat_q;
        for (int k = 0; k < LANES; k++) begin
            acc_d[k] = acc_q[k];
        end

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        if (clear) begin
            state_d = StIdle;
            count_d = '0;
            for (int k = 0; k < LANES; k++) begin
                acc_d[k] = '0;
            end
        end else if (fire) begin
            if (count_q == '0) begin
                len_d = eff_len;
            end
            if (last_beat) begin
                state_d = StIdle;
                count_d = '0;
                valid_d = 1'b1;
                data_d  = lane_res;
                sat_d   = lane_clip;
                for (int k = 0; k < LANES; k++) begin
                    acc_d[k] = '0;
                end
            end else begin
                state_d = StAccum;
                count_d = count_q + CNT_W'(1);
                for (int k = 0; k < LANES; k++) begin
                    acc_d[k] = sum_a[k];
                end
            end
        end else if (in_valid && !in_ready) begin
            state_d = StHold;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            count_q <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            sat_q   <= '0;
            for (int k = 0; k < LANES; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            sat_q   <= sat_d;
            for (int k = 0; k < LANES; k++) begin
                acc_q[k] <= acc_d[k];
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_sat   = sat_q;

endmodule

// File: tb/tb_conv_mac_array.sv
// Scoreboard bench for conv_mac_array: directed windows push expected results, a negedge
// monitor pops and compares on every output handshake.
module tb_conv_mac_array;

    localparam int DW = 9;
    localparam int L  = 4;
    localparam int OW = 21;
    localparam int CW = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic                clear;
    logic                relu_en;
    logic [CW-1:0]       win_len;
    logic                in_valid;
    logic                in_ready;
    logic signed [DW-1:0] pixel;
    logic [L*DW-1:0]     weight;
    logic                out_valid;
    logic                out_ready;
    logic [L*OW-1:0]     out_data;
    logic [L-1:0]        out_sat;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [L*OW-1:0] data;
        logic [L-1:0]    sat;
    } exp_t;

    exp_t sb[$];

    conv_mac_array dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .relu_en   (relu_en),
        .win_len   (win_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pixel     (pixel),
        .weight    (weight),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [L*DW-1:0] w4(input int a, input int b, input int c, input int d);
        return {DW'(d), DW'(c), DW'(b), DW'(a)};
    endfunction

    task automatic push(input int a0, input int a1, input int a2, input int a3,
                        input logic [L-1:0] s);
        exp_t e;
        e.data = {OW'(a3), OW'(a2), OW'(a1), OW'(a0)};
        e.sat  = s;
        sb.push_back(e);
    endtask

    task automatic beat(input int p, input logic [L*DW-1:0] w);
        int waited = 0;
        pixel    = DW'(p);
        weight   = w;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_assert++;
            n_fail++;
            $display("FAIL beat_timeout: got in_ready=0 expected in_ready=1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted result must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL unexpected_result: got %0h expected none", out_data);
                end else begin
                    e = sb.pop_front();
                    check("result_data", out_data, e.data);
                    check("result_sat", out_sat, e.sat);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        clear     = 1'b0;
        relu_en   = 1'b0;
        win_len   = CW'(4);
        in_valid  = 1'b0;
        pixel     = '0;
        weight    = '0;
        out_ready = 1'b1;
        #12;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_sat", out_sat, 0);
        check("reset_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Basic window of four beats on lane 0.
        beat(3, w4(2, 0, 0, 0));
        beat(-1, w4(5, 0, 0, 0));
        beat(4, w4(4, 0, 0, 0));
        check("valid_before_last", out_valid, 0);
        push(17, 0, 0, 0, 4'b0000);
        beat(0, w4(9, 0, 0, 0));
        check("valid_after_last", out_valid, 1);
        drain();

        // In-range large sum, then positive clip with a mid-window win_len change.
        win_len = CW'(9);
        push(585225, 0, 0, 0, 4'b0000);
        repeat (9) beat(255, w4(255, 0, 0, 0));
        win_len = CW'(20);
        push(1048575, 0, 0, 0, 4'b0001);
        beat(255, w4(255, 0, 0, 0));
        win_len = CW'(5);
        repeat (19) beat(255, w4(255, 0, 0, 0));

        // Negative clip, then the same with ReLU (flag still set).
        win_len = CW'(20);
        push(-1048576, 0, 0, 0, 4'b0001);
        repeat (20) beat(-256, w4(255, 0, 0, 0));
        relu_en = 1'b1;
        push(0, 0, 0, 0, 4'b0001);
        repeat (20) beat(-256, w4(255, 0, 0, 0));
        relu_en = 1'b0;

        // win_len of zero behaves as one.
        win_len = '0;
        push(20, 0, 0, 0, 4'b0000);
        beat(10, w4(2, 0, 0, 0));
        drain();

        // Back-pressure: second result's last beat stalls until out_ready.
        win_len   = CW'(2);
        out_ready = 1'b0;
        push(3, 3, 0, 0, 4'b0000);
        push(7, 7, 0, 0, 4'b0000);
        beat(1, w4(1, 1, 0, 0));
        beat(2, w4(1, 1, 0, 0));
        beat(3, w4(1, 1, 0, 0));
        pixel    = DW'(4);
        weight   = w4(1, 1, 0, 0);
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("held_data", out_data[OW-1:0], 3);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Clear after two beats, with a discarded beat alongside it.
        win_len = CW'(4);
        beat(5, w4(1, 0, 0, 0));
        beat(5, w4(1, 0, 0, 0));
        clear    = 1'b1;
        in_valid = 1'b1;
        pixel    = DW'(9);
        weight   = w4(9, 9, 9, 9);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        push(4, 0, 0, 0, 4'b0000);
        repeat (4) beat(1, w4(1, 0, 0, 0));
        drain();

        // Asynchronous reset mid-window drops the pending result immediately.
        out_ready = 1'b0;
        repeat (4) beat(2, w4(1, 0, 0, 0));
        check("pending_valid", out_valid, 1);
        check("pending_data", out_data[OW-1:0], 8);
        beat(2, w4(1, 0, 0, 0));
        beat(2, w4(1, 0, 0, 0));
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_valid", out_valid, 0);
        check("async_reset_data", out_data, 0);
        check("async_reset_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        out_ready = 1'b1;
        push(4, 0, 0, 0, 4'b0000);
        repeat (4) beat(1, w4(1, 0, 0, 0));
        drain();

        // Single-beat windows back to back, distinct weights per lane.
        win_len = CW'(1);
        push(3, -6, 9, -12, 4'b0000);
        beat(3, w4(1, -2, 3, -4));
        check("b2b_in_ready_0", in_ready, 1);
        check("b2b_valid_0", out_valid, 1);
        push(-5, 10, -15, 20, 4'b0000);
        beat(-5, w4(1, -2, 3, -4));
        check("b2b_in_ready_1", in_ready, 1);
        check("b2b_valid_1", out_valid, 1);
        push(7, -14, 21, -28, 4'b0000);
        beat(7, w4(1, -2, 3, -4));
        check("b2b_in_ready_2", in_ready, 1);
        check("b2b_valid_2", out_valid, 1);

        for (int i = 0; i < 50 && sb.size() != 0; i++) begin
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
